// File: rtl/al422_frame_reader.sv
// AL422 frame FIFO read controller. On a frame-ready pulse it rewinds the
// FIFO read pointer, clocks one frame of bytes out with OV_RCLK, packs them
// into PIX_W-bit pixels and presents them on a valid/ready stream.
//
// Stream handshake: PIX_DATA/PIX_SOF/PIX_EOL are valid while PIX_VALID=1 and
// transfer on a cycle with PIX_VALID && PIX_READY. Once raised, PIX_VALID and
// its payload stay stable until that transfer. PIX_VALID never depends on
// PIX_READY in the same cycle.
module al422_frame_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int PIX_W       = 16,
  parameter int RCLK_DIV    = 2,
  parameter int RRST_PULSES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FRAME_RDY,
  input  logic             SWAP_EN,
  input  logic             DEC_EN,
  input  logic [7:0]       OV_DATA_IN,
  output logic             OV_RRST,
  output logic             OV_RCLK,
  output logic [PIX_W-1:0] PIX_DATA,
  output logic             PIX_VALID,
  input  logic             PIX_READY,
  output logic             PIX_SOF,
  output logic             PIX_EOL,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic [7:0]       DROP_CNT,
  output logic [2:0]       DBG_STATE
);
  localparam int BPP = PIX_W / 8;
  localparam int BW  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int CW  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int DW  = (RCLK_DIV > 1) ? $clog2(RCLK_DIV) : 1;
  localparam int PW  = (RRST_PULSES > 1) ? $clog2(RRST_PULSES) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] DEC_COL_LAST = CW'(((H_ACTIVE - 1) / 2) * 2);
  localparam logic [RW-1:0] ROW_LAST     = RW'(V_ACTIVE - 1);
  localparam logic [DW-1:0] DIV_LAST     = DW'(RCLK_DIV - 1);
  localparam logic [PW-1:0] RRST_LAST    = PW'(RRST_PULSES - 1);
  localparam logic [BW-1:0] BYTE_LAST    = BW'(BPP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RRST  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]       state;
  logic             rclk, in_flight;
  logic [DW-1:0]    div_cnt;
  logic [PW-1:0]    rrst_cnt;
  logic [BW-1:0]    byte_cnt;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] pix_acc, pix_next, out_data;
  logic             swap, dec, pend;
  logic             out_valid, out_sof, out_eol;
  logic             hold_sof, hold_eol, hold_last;
  logic [7:0]       drop_cnt;

  logic high_end, low_end, start_pulse, capture, pix_done;
  logic present, sof_now, eol_now, last_now;
  logic accept, reg_free, frame_done_c, drop_inc;
  logic [BW-1:0] pos;

  // Pulse timing, capture point, pixel placement and frame position decode.
  always_comb begin
    high_end     = in_flight && rclk && (div_cnt == DIV_LAST);
    low_end      = in_flight && !rclk && (div_cnt == DIV_LAST);
    start_pulse  = ((state == S_READ) && (!in_flight || low_end)) ||
                   ((state == S_RRST) && (!in_flight || (low_end && rrst_cnt != RRST_LAST)));
    capture      = (state == S_READ) && high_end;
    pix_done     = capture && (byte_cnt == BYTE_LAST);
    pos          = swap ? byte_cnt : BYTE_LAST - byte_cnt;
    pix_next     = pix_acc;
    for (int i = 0; i < BPP; i++)
      if (pos == BW'(i)) pix_next[8*i +: 8] = OV_DATA_IN;
    present      = !dec || (!col[0] && !row[0]);
    sof_now      = (col == '0) && (row == '0);
    eol_now      = dec ? (col == DEC_COL_LAST) : (col == COL_LAST);
    last_now     = (col == COL_LAST) && (row == ROW_LAST);
    accept       = out_valid && PIX_READY;
    reg_free     = !out_valid || PIX_READY;
    frame_done_c = (state == S_DRAIN) && !out_valid && !in_flight;
    drop_inc     = FRAME_RDY && (state != S_IDLE) && pend;
  end

  // Read-clock generator: RCLK_DIV cycles high, RCLK_DIV low per pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rclk      <= 1'b0;
      in_flight <= 1'b0;
      div_cnt   <= '0;
    end else if (start_pulse) begin
      rclk      <= 1'b1;
      in_flight <= 1'b1;
      div_cnt   <= '0;
    end else if (in_flight) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (rclk) rclk <= 1'b0;
        else      in_flight <= 1'b0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Frame sequencing; mode bits are sampled whenever a frame read begins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      swap  <= 1'b0;
      dec   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (FRAME_RDY) begin
          state <= S_RRST;
          swap  <= SWAP_EN;
          dec   <= DEC_EN;
        end
        S_RRST: if (low_end && rrst_cnt == RRST_LAST) state <= S_READ;
        S_READ: if (pix_done) begin
          if (present && !reg_free) state <= S_HOLD;
          else if (last_now)        state <= S_DRAIN;
        end
        S_HOLD: if (reg_free) state <= hold_last ? S_DRAIN : S_READ;
        S_DRAIN: if (frame_done_c) begin
          if (pend || FRAME_RDY) begin
            state <= S_RRST;
            swap  <= SWAP_EN;
            dec   <= DEC_EN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Counts read-pointer reset pulses; restarts whenever RRST is left.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  rrst_cnt <= '0;
    else if (state != S_RRST) rrst_cnt <= '0;
    else if (low_end)         rrst_cnt <= rrst_cnt + 1'b1;
  end

  // One-deep frame queue and saturating drop counter; a request on the
  // done cycle with nothing pending is consumed directly by the restart.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (frame_done_c)                          pend <= 1'b0;
      else if (FRAME_RDY && state != S_IDLE)     pend <= 1'b1;
      if (drop_inc && drop_cnt != 8'hFF)         drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Byte assembly and source pixel position tracking.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      byte_cnt <= '0;
      col      <= '0;
      row      <= '0;
      pix_acc  <= '0;
    end else if (state == S_RRST) begin
      byte_cnt <= '0;
      col      <= '0;
      row      <= '0;
    end else if (capture) begin
      pix_acc <= pix_next;
      if (byte_cnt == BYTE_LAST) begin
        byte_cnt <= '0;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // Output register; a blocked pixel waits in pix_acc with its flags saved.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      hold_sof  <= 1'b0;
      hold_eol  <= 1'b0;
      hold_last <= 1'b0;
    end else if (pix_done && present) begin
      if (reg_free) begin
        out_valid <= 1'b1;
        out_data  <= pix_next;
        out_sof   <= sof_now;
        out_eol   <= eol_now;
      end else begin
        hold_sof  <= sof_now;
        hold_eol  <= eol_now;
        hold_last <= last_now;
      end
    end else if (state == S_HOLD && reg_free) begin
      out_valid <= 1'b1;
      out_data  <= pix_acc;
      out_sof   <= hold_sof;
      out_eol   <= hold_eol;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  assign OV_RRST    = (state != S_RRST);
  assign OV_RCLK    = rclk;
  assign PIX_DATA   = out_data;
  assign PIX_VALID  = out_valid;
  assign PIX_SOF    = out_sof;
  assign PIX_EOL    = out_eol;
  assign BUSY       = (state != S_IDLE);
  assign FRAME_DONE = frame_done_c;
  assign DROP_CNT   = drop_cnt;
  assign DBG_STATE  = state;
endmodule
